// File: rtl/leaf_tx_queue.sv
// leaf_tx_queue
//   Transmit stage between a processing element and one network leaf port.
//   Words offered by the PE are turned into packets {valid, dest, src, data}
//   when they are pushed, and held in a small FIFO. The head packet is loaded
//   into an output register that drives bus_o. It is re-driven while the
//   network asserts resend, so a rejected packet is never lost or reordered.
//
// Ports
//   clk         clock
//   reset       synchronous, active-high reset
//   in_valid    PE offers a word
//   in_ready    queue can accept (depends only on the queued-entry count)
//   in_dest     destination leaf address
//   in_data     user data
//   bus_o       packet to network; MSB is valid; all zeros when idle
//   resend      network rejected the packet currently on bus_o
//   fifo_count  entries queued, not counting the packet on bus_o
//   retry_cnt   saturating count of edges with bus_o valid && resend
module leaf_tx_queue #(
   parameter  int num_leaves = 8,
   parameter  int addr       = 0,
   parameter  int data_sz    = 4,
   parameter  int fifo_depth = 4,
   localparam int addr_w     = $clog2(num_leaves),
   localparam int payload_sz = addr_w + data_sz,
   localparam int p_sz       = 1 + addr_w + payload_sz,
   localparam int cnt_w      = $clog2(fifo_depth) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [addr_w-1:0]  in_dest,
   input  logic [data_sz-1:0] in_data,
   output logic [p_sz-1:0]    bus_o,
   input  logic               resend,
   output logic [cnt_w-1:0]   fifo_count,
   output logic [15:0]        retry_cnt
);

   localparam int PTR_W = $clog2(fifo_depth);
   localparam logic [addr_w-1:0] SRC_ADDR = addr_w'(addr);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

   state_e             state_q, state_d;
   logic [p_sz-1:0]    mem_q [fifo_depth];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [cnt_w-1:0]   count_q, count_d;
   logic [p_sz-1:0]    out_q, out_d;
   logic [15:0]        retry_q, retry_d;
   logic               push_s;
   logic               pop_s;
   logic               fifo_nonempty_s;

   // Acceptance looks only at the stored count, so a full queue refuses a
   // word even on an edge where the head is being popped.
   assign in_ready        = (count_q < cnt_w'(fifo_depth));
   assign push_s          = in_valid && in_ready;
   assign fifo_nonempty_s = (count_q != {cnt_w{1'b0}});

   assign bus_o      = out_q;
   assign fifo_count = count_q;
   assign retry_cnt  = retry_q;

   // Output-register FSM: next packet, pop decision, retry accounting.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      retry_d = retry_q;
      pop_s   = 1'b0;
      case (state_q)
         SEND: begin
            if (resend) begin
               // Hold the rejected packet; nothing behind it may overtake.
               if (retry_q != 16'hFFFF) begin
                  retry_d = retry_q + 16'd1;
               end else begin
                  retry_d = retry_q;
               end
            end else if (fifo_nonempty_s) begin
               pop_s   = 1'b1;
               out_d   = mem_q[rd_ptr_q];
               state_d = SEND;
            end else begin
               out_d   = {p_sz{1'b0}};
               state_d = IDLE;
            end
         end
         IDLE: begin
            // resend has no meaning while nothing is being driven.
            if (fifo_nonempty_s) begin
               pop_s   = 1'b1;
               out_d   = mem_q[rd_ptr_q];
               state_d = SEND;
            end else begin
               out_d   = {p_sz{1'b0}};
               state_d = IDLE;
            end
         end
         default: begin
            out_d   = {p_sz{1'b0}};
            state_d = IDLE;
         end
      endcase
   end

   // FIFO pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {{(cnt_w-1){1'b0}}, push_s} - {{(cnt_w-1){1'b0}}, pop_s};
   end

   // State, pointer, output and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= {PTR_W{1'b0}};
         rd_ptr_q <= {PTR_W{1'b0}};
         count_q  <= {cnt_w{1'b0}};
         out_q    <= {p_sz{1'b0}};
         retry_q  <= 16'h0000;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         out_q    <= out_d;
         retry_q  <= retry_d;
      end
   end

   // FIFO storage; the packet is assembled at push time.
   always_ff @(posedge clk) begin
      if (!reset && push_s) begin
         mem_q[wr_ptr_q] <= {1'b1, in_dest, SRC_ADDR, in_data};
      end
   end

endmodule

// File: tb/tb_leaf_tx_queue.sv
// tb_leaf_tx_queue
//   Directed bench for leaf_tx_queue (num_leaves=8, addr=3, data_sz=4).
//   Inputs change 1 time unit after each rising edge; outputs are checked
//   at that same point, away from the active edge.
module tb_leaf_tx_queue;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_dest;
   logic [3:0]  in_data;
   logic [10:0] bus_o;
   logic        resend;
   logic [2:0]  fifo_count;
   logic [15:0] retry_cnt;

   int n_checks;
   int n_errors;

   leaf_tx_queue #(
      .num_leaves(8),
      .addr(3),
      .data_sz(4),
      .fifo_depth(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_dest(in_dest),
      .in_data(in_data),
      .bus_o(bus_o),
      .resend(resend),
      .fifo_count(fifo_count),
      .retry_cnt(retry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected packet from this leaf (source address 3).
   function automatic logic [10:0] pkt(input logic [2:0] d, input logic [3:0] v);
      return {1'b1, d, 3'd3, v};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [2:0] d, input logic [3:0] v);
      in_valid = 1'b1;
      in_dest  = d;
      in_data  = v;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_dest  = 3'd0;
      in_data  = 4'd0;
      resend   = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check_eq("rst_bus", 32'(bus_o), 32'h0);
      check_eq("rst_cnt", 32'(fifo_count), 32'd0);
      check_eq("rst_retry", 32'(retry_cnt), 32'd0);
      check_eq("rst_ready", 32'(in_ready), 32'd1);

      // Single word: dest 5, data A -> 11'b1_101_011_1010 = 0x6BA
      offer(3'd5, 4'hA);
      tick();
      in_valid = 1'b0;
      check_eq("single_cnt1", 32'(fifo_count), 32'd1);
      check_eq("single_nobypass", 32'(bus_o), 32'h0);
      tick();
      check_eq("single_bus", 32'(bus_o), 32'h6BA);
      check_eq("single_cnt0", 32'(fifo_count), 32'd0);
      tick();
      check_eq("single_idle", 32'(bus_o), 32'h0);

      // Retry: packet held for 3 resend edges, follower waits
      offer(3'd5, 4'hA);
      tick();
      offer(3'd2, 4'h7);
      tick();
      in_valid = 1'b0;
      resend   = 1'b1;
      check_eq("retry_c1", 32'(bus_o), 32'h6BA);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("retry_hold", 32'(bus_o), 32'h6BA);
      end
      resend = 1'b0;
      check_eq("retry_cnt3", 32'(retry_cnt), 32'd3);
      tick();
      check_eq("retry_next", 32'(bus_o), 32'(pkt(3'd2, 4'h7)));
      tick();
      check_eq("retry_idle", 32'(bus_o), 32'h0);

      // Full: resend held, 5 accepted (1 in out_reg, 4 queued), 6th refused
      resend = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         check_eq("full_ready", 32'(in_ready), 32'd1);
         offer(3'(i), 4'(i));
         tick();
      end
      check_eq("full_cnt", 32'(fifo_count), 32'd4);
      check_eq("full_notready", 32'(in_ready), 32'd0);
      offer(3'd7, 4'hF);
      tick();
      in_valid = 1'b0;
      check_eq("full_refused", 32'(fifo_count), 32'd4);
      check_eq("full_retry", 32'(retry_cnt), 32'd7);
      resend = 1'b0;
      check_eq("full_out1", 32'(bus_o), 32'(pkt(3'd1, 4'd1)));
      for (int i = 2; i <= 5; i++) begin
         tick();
         check_eq("full_order", 32'(bus_o), 32'(pkt(3'(i), 4'(i))));
      end
      tick();
      check_eq("full_drained", 32'(bus_o), 32'h0);
      check_eq("full_cnt0", 32'(fifo_count), 32'd0);

      // Wrap: stream of 10 words, no bubbles after the first
      for (int i = 0; i < 10; i++) begin
         offer(3'(i % 8), 4'(i));
         tick();
         if (i >= 1) begin
            check_eq("wrap_seq", 32'(bus_o), 32'(pkt(3'((i - 1) % 8), 4'(i - 1))));
         end
      end
      in_valid = 1'b0;
      tick();
      check_eq("wrap_last", 32'(bus_o), 32'(pkt(3'd1, 4'd9)));
      tick();
      check_eq("wrap_idle", 32'(bus_o), 32'h0);

      // Reset mid-operation, with a word offered during the reset edge
      resend = 1'b1;
      for (int i = 0; i < 4; i++) begin
         offer(3'd6, 4'(i + 12));
         tick();
      end
      check_eq("mid_cnt3", 32'(fifo_count), 32'd3);
      check_eq("mid_bus", 32'(bus_o), 32'(pkt(3'd6, 4'd12)));
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      resend   = 1'b0;
      check_eq("mid_rst_bus", 32'(bus_o), 32'h0);
      check_eq("mid_rst_cnt", 32'(fifo_count), 32'd0);
      check_eq("mid_rst_retry", 32'(retry_cnt), 32'd0);
      check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("mid_no_stale", 32'(bus_o), 32'h0);
      end

      // Saturation: 70000 retry edges
      resend = 1'b1;
      offer(3'd3, 4'h5);
      tick();
      in_valid = 1'b0;
      tick();
      check_eq("sat_loaded", 32'(bus_o), 32'(pkt(3'd3, 4'h5)));
      for (int i = 0; i < 70000; i++) begin
         tick();
      end
      check_eq("sat_cnt", 32'(retry_cnt), 32'hFFFF);
      check_eq("sat_hold", 32'(bus_o), 32'(pkt(3'd3, 4'h5)));
      for (int i = 0; i < 5; i++) begin
         tick();
      end
      check_eq("sat_stay", 32'(retry_cnt), 32'hFFFF);
      resend = 1'b0;
      tick();
      check_eq("sat_release", 32'(bus_o), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/leaf_tx_queue.md
Name: leaf_tx_queue

Overview:
- Leaf-side transmit stage between a processing element and one gen_nw leaf port (drives pe_interface slice j, consumes resend[j]).
- Accepts (destination, data) words from the PE over a valid/ready handshake and buffers them in a small FIFO.
- Assembles each word into a network packet and presents it on bus_o.
- Re-drives the same packet while the network asserts resend, so no packet is lost under contention.

Parameters:
- num_leaves, 8, number of network leaves; power of 2, >=2; addr_w = $clog2(num_leaves).
- addr, 0, this leaf's address; addr_w bits.
- data_sz, 4, user data bits per packet.
- payload_sz, addr_w+data_sz, packet payload: {source addr, data}.
- p_sz, 1+addr_w+payload_sz, packet width: {valid, dest, src, data}.
- fifo_depth, 4, FIFO entries; power of 2, >=2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  PE offers a word.
- in_ready  out  1  queue can accept; word accepted on an edge where in_valid && in_ready.
- in_dest  in  addr_w  destination leaf address.
- in_data  in  data_sz  user data.
- bus_o  out  p_sz  packet to network; bit p_sz-1 = valid; all zeros when idle.
- resend  in  1  network rejected the packet currently on bus_o.
- fifo_count  out  $clog2(fifo_depth)+1  entries queued, excluding the packet on bus_o.
- retry_cnt  out  16  count of edges with bus_o valid && resend; saturates at 16'hFFFF.

Behaviour:
- Packet format: {1'b1, in_dest, addr, in_data}, MSB first; formed at FIFO push.
- Reset (synchronous): FIFO emptied, pointers 0, fifo_count=0, bus_o=0, retry_cnt=0.
- in_ready = (fifo_count < fifo_depth); combinational from count only, with no dependence on pop.
- When fifo_count == fifo_depth, in_ready = 0 even if a pop occurs on the same edge.
- bus_o is a register (out_reg). bus_o has two states:
  - IDLE: out_reg valid bit 0.
  - SEND: out_reg valid bit 1.
- Per posedge, when not in reset:
  - SEND && resend=1: out_reg holds; retry_cnt += 1 (saturating); FIFO not popped.
  - SEND && resend=0, or IDLE: if FIFO non-empty, pop the head into out_reg (state SEND). Otherwise out_reg = 0 (state IDLE).
  - resend is ignored in IDLE.
- No bypass. A word pushed at edge t can load into out_reg at edge t+1 at the earliest. bus_o is valid during the cycle after edge t+1.
- Back-to-back: when resend stays 0, consecutive queued packets appear on bus_o in consecutive cycles with no bubble.
- Simultaneous push and pop: both happen; fifo_count unchanged. With an empty FIFO and IDLE, the push lands in the FIFO and the pop does not occur on that edge.
- FIFO ordering is strict FIFO. Pointers wrap modulo fifo_depth; full/empty are distinguished by fifo_count.
- Order is preserved across retries; a held packet is never reordered behind later ones.
- Self-addressed words (in_dest == addr) are sent like any other.
- Reset mid-operation: all queued and held packets are discarded; bus_o = 0 in the cycle after the reset edge.
- Word accepted while reset=1: ignored.

Test Plan:
- Setup for all cases: num_leaves=8, addr=3, data_sz=4, p_sz=11.
- Single word: push dest=5, data=4'hA at edge t, resend=0 → bus_o=11'b1_101_011_1010 for exactly one cycle after edge t+1, then 0; fifo_count returns to 0.
- Retry: same packet, resend=1 for 3 edges while it is valid → bus_o constant for 4 cycles; retry_cnt=3; next packet follows only after resend drops.
- Full: hold resend=1, push 5 words → words 1..5 accepted (1 in out_reg, 4 in FIFO); fifo_count=4, in_ready=0. A sixth push is refused. Release resend → packets emerge in push order on 5 consecutive cycles.
- Wrap: stream 10 words (data 0..9, dest cycling 0..7) with resend=0 and in_valid held → bus_o shows data 0..9 in order, no gaps after the first; pointers wrap cleanly.
- Reset mid-operation: 3 queued plus 1 on bus_o, assert reset for 1 edge → bus_o=0, fifo_count=0, retry_cnt=0, in_ready=1; no stale packet appears afterwards.
- Saturation (forced via long resend): 70000 retry edges → retry_cnt=16'hFFFF, stays there.
